// File: rtl/fwd_scoreboard_if.sv
// Operand-forwarding bus between the EX stage and fwd_scoreboard.
// The master side drives the EX instruction and stage results; the slave side returns forwarding and stall.
interface fwd_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 3
);
  logic                               ex_valid;
  logic                               ex_regwrite;
  logic                               ex_memread;
  logic [REG_ADDR_WIDTH-1:0]          ex_rd;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  ex_rs;
  logic                               flush;
  logic [DEPTH*REG_DATA_WIDTH-1:0]    stage_data;
  logic [NUM_SRC-1:0]                 fwd_hit;
  logic [NUM_SRC*REG_DATA_WIDTH-1:0]  fwd_data;
  logic                               stall;

  modport master (
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, flush, stage_data,
    input  fwd_hit, fwd_data, stall
  );

  modport slave (
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, flush, stage_data,
    output fwd_hit, fwd_data, stall
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit tracking in-flight writers in a DEPTH-entry shift register.
// Optional stall cycle counter output stall_cnt enabled by macro FWD_STALL_CNT_EN.
module fwd_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 3,
  parameter int LOAD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  fwd_scoreboard_if.slave   bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic                      r_v  [DEPTH];
  logic                      r_ld [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] r_rd [DEPTH];

  logic [NUM_SRC-1:0]                w_hit;
  logic [NUM_SRC-1:0]                w_not_ready;
  logic [NUM_SRC*REG_DATA_WIDTH-1:0] w_fwd_data;
  logic                              w_stall;
  logic                              w_push;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_WIDTH-1:0] w_rs;
      logic                      w_found;
      logic                      w_ready;
      logic [REG_DATA_WIDTH-1:0] w_data;

      assign w_rs = bus.ex_rs[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

      // Scan oldest to youngest so the youngest match overwrites older ones.
      always_comb begin
        w_found = 1'b0;
        w_ready = 1'b0;
        w_data  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (r_v[k] && (r_rd[k] == w_rs) && (w_rs != '0)) begin
            w_found = 1'b1;
            w_ready = !r_ld[k] || (k >= LOAD_LAT);
            w_data  = bus.stage_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
          end
        end
      end

      assign w_hit[gi]       = w_found & w_ready;
      assign w_not_ready[gi] = w_found & ~w_ready;
      assign w_fwd_data[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = w_hit[gi] ? w_data : '0;
    end
  endgenerate

  assign w_stall = bus.ex_valid & ~bus.flush & (|w_not_ready);
  assign w_push  = bus.ex_valid & bus.ex_regwrite & (bus.ex_rd != '0) & ~w_stall & ~bus.flush;

  assign bus.fwd_hit  = w_hit;
  assign bus.fwd_data = w_fwd_data;
  assign bus.stall    = w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v[0]  <= 1'b0;
      r_ld[0] <= 1'b0;
      r_rd[0] <= '0;
    end else begin
      r_v[0]  <= w_push;
      r_ld[0] <= w_push & bus.ex_memread;
      r_rd[0] <= w_push ? bus.ex_rd : '0;
    end
  end

  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v[gi]  <= 1'b0;
          r_ld[gi] <= 1'b0;
          r_rd[gi] <= '0;
        end else begin
          r_v[gi]  <= r_v[gi-1];
          r_ld[gi] <= r_ld[gi-1];
          r_rd[gi] <= r_rd[gi-1];
        end
      end
    end
  endgenerate

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: one default instance (LOAD_LAT=1) and one with LOAD_LAT=2.
// Exercises the stall counter as well when FWD_STALL_CNT_EN is defined.
module tb_fwd_scoreboard;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  fwd_scoreboard_if #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32), .NUM_SRC(2), .DEPTH(3)) ifa ();
  fwd_scoreboard_if #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32), .NUM_SRC(2), .DEPTH(3)) ifb ();

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_a;
  logic [31:0] cnt_b;
`endif

  fwd_scoreboard #(.LOAD_LAT(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt (cnt_a)
`endif
  );

  fwd_scoreboard #(.LOAD_LAT(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_a(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs0, input logic [4:0] rs1, input logic fl);
    ifa.ex_valid    = v;
    ifa.ex_regwrite = rw;
    ifa.ex_memread  = mr;
    ifa.ex_rd       = rd;
    ifa.ex_rs       = {rs1, rs0};
    ifa.flush       = fl;
  endtask

  task automatic ex_b(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs0, input logic [4:0] rs1, input logic fl);
    ifb.ex_valid    = v;
    ifb.ex_regwrite = rw;
    ifb.ex_memread  = mr;
    ifb.ex_rd       = rd;
    ifb.ex_rs       = {rs1, rs0};
    ifb.flush       = fl;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    ex_a(0, 0, 0, 0, 0, 0, 0);
    ex_b(0, 0, 0, 0, 0, 0, 0);
    ifa.stage_data = '0;
    ifb.stage_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    ex_a(1, 0, 0, 0, 5, 5, 0);
    ifa.stage_data = {32'h3, 32'h2, 32'h1};
    #1;
    chk("reset_hit", ifa.fwd_hit, 2'b00);
    chk("reset_data", ifa.fwd_data, 64'h0);
    chk("reset_stall", ifa.stall, 1'b0);
`ifdef FWD_STALL_CNT_EN
    chk("reset_cnt", cnt_a, 32'd0);
`endif

    // add x5, then consumer at entry 0
    ex_a(1, 1, 0, 5, 0, 0, 0);
    #1;
    chk("add_push_stall", ifa.stall, 1'b0);
    tick();
    ex_a(1, 0, 0, 0, 5, 0, 0);
    ifa.stage_data = {32'h0, 32'h0, 32'h1234};
    #1;
    chk("fwd_e0_hit", ifa.fwd_hit, 2'b01);
    chk("fwd_e0_data", ifa.fwd_data, {32'h0, 32'h1234});
    chk("fwd_e0_stall", ifa.stall, 1'b0);
    tick();

    // Two writers of x7: youngest wins
    ex_a(1, 1, 0, 7, 0, 0, 0);
    tick();
    ex_a(1, 1, 0, 7, 0, 0, 0);
    tick();
    ex_a(1, 0, 0, 0, 7, 0, 0);
    ifa.stage_data = {32'h0, 32'hBBBB, 32'hAAAA};
    #1;
    chk("youngest_hit", ifa.fwd_hit, 2'b01);
    chk("youngest_data", ifa.fwd_data, {32'h0, 32'hAAAA});
    tick();

    // Load x9 then use on rs1: one stall cycle, no push, then forward from entry 1
    ex_a(1, 1, 1, 9, 0, 0, 0);
    tick();
    ex_a(1, 1, 0, 10, 0, 9, 0);
    ifa.stage_data = {32'hCCCC, 32'h9999, 32'hDDDD};
    #1;
    chk("ld_use_stall", ifa.stall, 1'b1);
    chk("ld_use_hit", ifa.fwd_hit, 2'b00);
    chk("ld_use_data", ifa.fwd_data, 64'h0);
    tick();
    #1;
    chk("ld_fwd_stall", ifa.stall, 1'b0);
    chk("ld_fwd_hit", ifa.fwd_hit, 2'b10);
    chk("ld_fwd_data", ifa.fwd_data, {32'h9999, 32'h0});
    tick();
    // x10 pushed after the stall released; now at entry 0
    ex_a(1, 0, 0, 0, 10, 0, 0);
    ifa.stage_data = {32'h0, 32'h0, 32'h1010};
    #1;
    chk("post_stall_push", ifa.fwd_data, {32'h0, 32'h1010});

    // rd = x0 writer is never tracked
    ex_a(1, 1, 0, 0, 0, 0, 0);
    tick();
    ex_a(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_hit", ifa.fwd_hit, 2'b00);
    chk("x0_stall", ifa.stall, 1'b0);
    tick();

    // Load-use with flush: no stall, no push
    ex_a(1, 1, 1, 11, 0, 0, 0);
    tick();
    ex_a(1, 1, 0, 12, 11, 0, 1);
    #1;
    chk("flush_stall", ifa.stall, 1'b0);
    chk("flush_hit", ifa.fwd_hit, 2'b00);
    tick();
    ex_a(1, 0, 0, 0, 12, 11, 0);
    ifa.stage_data = {32'h0, 32'h5555, 32'h0};
    #1;
    chk("flush_nopush_hit", ifa.fwd_hit, 2'b10);
    chk("flush_nopush_data", ifa.fwd_data, {32'h5555, 32'h0});
    chk("flush_nopush_stall", ifa.stall, 1'b0);
    tick();

    // Fill three entries, then reset mid-stream
    ex_a(1, 1, 0, 1, 0, 0, 0);
    tick();
    ex_a(1, 1, 0, 2, 0, 0, 0);
    tick();
    ex_a(1, 1, 0, 3, 0, 0, 0);
    tick();
    ex_a(1, 0, 0, 0, 1, 3, 0);
    ifa.stage_data = {32'h0111, 32'h0222, 32'h0333};
    #1;
    chk("full_hit", ifa.fwd_hit, 2'b11);
    chk("full_data", ifa.fwd_data, {32'h0333, 32'h0111});
    ex_a(1, 0, 0, 0, 2, 2, 0);
    #1;
    chk("same_reg_data", ifa.fwd_data, {32'h0222, 32'h0222});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_a(1, 0, 0, 0, 1, 3, 0);
    #1;
    chk("rst_mid_hit", ifa.fwd_hit, 2'b00);
    chk("rst_mid_data", ifa.fwd_data, 64'h0);
    chk("rst_mid_stall", ifa.stall, 1'b0);
`ifdef FWD_STALL_CNT_EN
    chk("rst_mid_cnt", cnt_a, 32'd0);
    for (int n = 0; n < 3; n++) begin
      ex_a(1, 1, 1, 20, 0, 0, 0);
      tick();
      ex_a(1, 0, 0, 0, 20, 0, 0);
      #1;
      chk("cnt_stall", ifa.stall, 1'b1);
      tick();
    end
    ex_a(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("cnt_three", cnt_a, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("cnt_cleared", cnt_a, 32'd0);
`endif
    ex_a(0, 0, 0, 0, 0, 0, 0);

    // LOAD_LAT = 2 instance: load-use stalls for two cycles
    ex_b(1, 1, 1, 9, 0, 0, 0);
    tick();
    ex_b(1, 1, 0, 10, 0, 9, 0);
    ifb.stage_data = {32'h3333, 32'h2222, 32'h1111};
    #1;
    chk("lat2_stall0", ifb.stall, 1'b1);
    tick();
    #1;
    chk("lat2_stall1", ifb.stall, 1'b1);
    chk("lat2_hit1", ifb.fwd_hit, 2'b00);
    tick();
    #1;
    chk("lat2_stall2", ifb.stall, 1'b0);
    chk("lat2_hit2", ifb.fwd_hit, 2'b10);
    chk("lat2_data2", ifb.fwd_data, {32'h3333, 32'h0});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
